pa_resp_buffer: RTL

Response buffer directly downstream of the page-walk unit's physical-address output port. It accepts translated PAs and fault flags over a valid/ready handshake and stores them in order in a DEPTH-entry FIFO. It presents them to the consumer over a second valid/ready handshake and keeps saturating translation and fault statistics. Back-pressure from the consumer reaches the walkers only through `pa_rdy_o`.

---
 rtl/pa_resp_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/pa_resp_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pa_resp_buffer
//  Description : In-order response FIFO between the page-walk unit and its
//                consumer. It buffers {fault, PA} pairs over valid/ready
//                handshakes and keeps saturating translation and fault counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module pa_resp_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic [31:0]            pa_i,
    input  logic                   pa_fault_i,
    input  logic                   pa_vld_i,
    output logic                   pa_rdy_o,
    output logic [31:0]            out_pa_o,
    output logic                   out_fault_o,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [CNT_W-1:0]       xlat_cnt_o,
    output logic [CNT_W-1:0]       fault_cnt_o,
    input  logic                   cnt_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = '0;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Storage: each entry holds {fault, pa}.
    logic [32:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] xlat_cnt;
    logic [CNT_W-1:0] fault_cnt;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy (plus reset), so consumer
    // back-pressure never forms a combinational path to the walkers.
    assign pa_rdy_o    = resetn_i && (level != LVL_FULL);
    assign out_vld_o   = (level != LVL_ZERO);
    assign push        = pa_vld_i && pa_rdy_o;
    assign pop         = out_vld_o && out_rdy_i;

    // Output always comes from the stored head entry; there is no bypass path.
    assign out_pa_o    = mem[rd_ptr][31:0];
    assign out_fault_o = mem[rd_ptr][32];

    assign level_o     = level;
    assign full_o      = (level == LVL_FULL);
    assign empty_o     = (level == LVL_ZERO);
    assign xlat_cnt_o  = xlat_cnt;
    assign fault_cnt_o = fault_cnt;

    // Entry array write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {pa_fault_i, pa_i};
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Saturating delivery statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (!resetn_i || cnt_clr_i) begin
            xlat_cnt  <= '0;
            fault_cnt <= '0;
        end else if (pop) begin
            if (xlat_cnt != CNT_MAX) begin
                xlat_cnt <= xlat_cnt + CNT_ONE;
            end
            if (out_fault_o && (fault_cnt != CNT_MAX)) begin
                fault_cnt <= fault_cnt + CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
